// File: rtl/sram_sp_par_wrap_if.sv
// Client-side bus of the parity-protected SRAM wrapper.
// master: ME/WE/ADR/D/inj_par out; Q/Q_vld/par_err/rdy in. slave: mirror.
interface sram_sp_par_wrap_if #(
  parameter int DW = 8,
  parameter int AW = 9
);
  logic          ME;
  logic          WE;
  logic [AW-1:0] ADR;
  logic [DW-1:0] D;
  logic          inj_par;
  logic [DW-1:0] Q;
  logic          Q_vld;
  logic          par_err;
  logic          rdy;

  modport master (
    output ME, WE, ADR, D, inj_par,
    input  Q, Q_vld, par_err, rdy
  );

  modport slave (
    input  ME, WE, ADR, D, inj_par,
    output Q, Q_vld, par_err, rdy
  );
endinterface

// File: rtl/sram_sp_par_wrap.sv
// Single-port SRAM wrapper: even parity per word, clear-on-reset, power-down.
// Ports: CLK, reset (sync, high), bus (slave), pd_req, scan_mode, par_err_adr, err_cnt, pd_ack.
module sram_sp_par_wrap #(
  parameter int DW            = 8,
  parameter int AW            = 9,
  parameter int INIT_ON_RESET = 1,
  parameter int WAKE_CYC      = 4,
  parameter int ERRCNT_W      = 8
) (
  input  logic                CLK,
  input  logic                reset,
  sram_sp_par_wrap_if.slave   bus,
  input  logic                pd_req,
  input  logic                scan_mode,
  output logic [AW-1:0]       par_err_adr,
  output logic [ERRCNT_W-1:0] err_cnt,
  output logic                pd_ack
);

  localparam int DEPTH = 2 ** AW;
  localparam int WCW   = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_PD,
    S_WAKE
  } state_t;

  state_t        state;
  logic [AW-1:0] init_adr;
  logic [WCW-1:0] wake_cnt;

  logic [DW:0]   mem [DEPTH];
  logic [DW:0]   rd_w;
  logic          rd_err;
  logic          acc;
  logic          init_wr;
  logic          usr_wr;
  logic          wr_en;
  logic [AW-1:0] wr_adr;
  logic [DW:0]   wr_w;

  assign bus.rdy = (state == S_IDLE) && !scan_mode;
  assign acc     = bus.ME && bus.rdy;

  assign rd_w   = mem[bus.ADR];
  assign rd_err = rd_w[DW] ^ (^rd_w[DW-1:0]);

  assign init_wr = (state == S_INIT) && !scan_mode && !reset;
  assign usr_wr  = acc && bus.WE && !reset;

  always_comb begin
    wr_en  = 1'b0;
    wr_adr = bus.ADR;
    wr_w   = {(^bus.D) ^ bus.inj_par, bus.D};
    unique case (1'b1)
      init_wr: begin
        wr_en  = 1'b1;
        wr_adr = init_adr;
        wr_w   = '0;
      end
      usr_wr: wr_en = 1'b1;
      default: ;
    endcase
  end

  // Array is never reset; only the clear engine zeroes it.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_adr] <= wr_w;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state       <= (INIT_ON_RESET != 0) ? S_INIT : S_IDLE;
      init_adr    <= '0;
      wake_cnt    <= '0;
      bus.Q       <= '0;
      bus.Q_vld   <= 1'b0;
      bus.par_err <= 1'b0;
      par_err_adr <= '0;
      err_cnt     <= '0;
      pd_ack      <= 1'b0;
    end else begin
      bus.Q_vld   <= 1'b0;
      bus.par_err <= 1'b0;
      if (acc && !bus.WE) begin
        bus.Q       <= rd_w[DW-1:0];
        bus.Q_vld   <= 1'b1;
        bus.par_err <= rd_err;
        if (rd_err) begin
          par_err_adr <= bus.ADR;
          if (!(&err_cnt)) err_cnt <= err_cnt + 1'b1;
        end
      end
      if (!scan_mode) begin
        unique case (state)
          S_INIT: begin
            init_adr <= init_adr + 1'b1;
            if (&init_adr) state <= S_IDLE;
          end
          // A pending access wins; power-down waits for an idle cycle.
          S_IDLE: begin
            if (pd_req && !acc) begin
              state  <= S_PD;
              pd_ack <= 1'b1;
            end
          end
          S_PD: begin
            if (!pd_req) begin
              state    <= S_WAKE;
              pd_ack   <= 1'b0;
              wake_cnt <= WCW'(WAKE_CYC - 1);
            end
          end
          S_WAKE: begin
            if (wake_cnt == '0) state <= S_IDLE;
            else wake_cnt <= wake_cnt - 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sram_sp_par_wrap.sv
// Scoreboard bench for sram_sp_par_wrap: random traffic vs. array model.
// Ports: none (drives the DUT through its bus interface).
module tb_sram_sp_par_wrap;

  localparam int DW    = 8;
  localparam int AW    = 9;
  localparam int DEPTH = 512;
  localparam int WAKE  = 4;
  localparam int EW    = 8;
  localparam int CMAX  = (1 << EW) - 1;

  logic          CLK = 1'b0;
  logic          reset = 1'b1;
  logic          pd_req = 1'b0;
  logic          scan_mode = 1'b0;
  logic [AW-1:0] par_err_adr;
  logic [EW-1:0] err_cnt;
  logic          pd_ack;

  sram_sp_par_wrap_if #(.DW(DW), .AW(AW)) bus ();

  sram_sp_par_wrap #(
    .DW(DW), .AW(AW), .INIT_ON_RESET(1),
    .WAKE_CYC(WAKE), .ERRCNT_W(EW)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .bus(bus),
    .pd_req(pd_req),
    .scan_mode(scan_mode),
    .par_err_adr(par_err_adr),
    .err_cnt(err_cnt),
    .pd_ack(pd_ack)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] q;
    logic          pe;
    logic [AW-1:0] a;
    int            c;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] m_d [DEPTH];
  bit            m_bad [DEPTH];
  int            m_cnt;
  logic [AW-1:0] m_adr;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got event want none", nm);
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_d[i]   = '0;
      m_bad[i] = 1'b0;
    end
    sb.delete();
    m_cnt = 0;
    m_adr = '0;
  endtask

  // One access attempt; the model only moves if the DUT can accept it.
  task automatic issue(input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit inj);
    exp_t e;
    bus.ME      = 1'b1;
    bus.WE      = we;
    bus.ADR     = a;
    bus.D       = d;
    bus.inj_par = inj;
    if (bus.rdy) begin
      if (we) begin
        m_d[a]   = d;
        m_bad[a] = inj;
      end else begin
        e.q  = m_d[a];
        e.pe = m_bad[a];
        e.a  = a;
        e.c  = cyc;
        sb.push_back(e);
      end
    end
    @(negedge CLK);
    bus.ME = 1'b0;
  endtask

  task automatic wait_rdy(output int n);
    n = 0;
    while (!bus.rdy && n < 2000) begin
      @(negedge CLK);
      n++;
    end
  endtask

  initial begin : mon
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!reset) begin
        if (bus.par_err && !bus.Q_vld) fail("stray_par_err");
        if (bus.Q_vld) begin
          if (sb.size() == 0) begin
            fail("unexpected_qvld");
          end else begin
            e = sb.pop_front();
            chk("q", bus.Q, e.q);
            chk("par_err", bus.par_err, e.pe);
            chk("latency", cyc - e.c, 1);
            if (e.pe) begin
              m_adr = e.a;
              if (m_cnt < CMAX) m_cnt++;
            end
            chk("err_cnt", err_cnt, m_cnt);
            chk("err_adr", par_err_adr, m_adr);
          end
        end
      end
    end
  end

  initial begin : stim
    int n;
    int k;
    bus.ME      = 1'b0;
    bus.WE      = 1'b0;
    bus.ADR     = '0;
    bus.D       = '0;
    bus.inj_par = 1'b0;
    model_clear();

    reset = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_q", bus.Q, 0);
    chk("rst_qvld", bus.Q_vld, 0);
    chk("rst_perr", bus.par_err, 0);
    chk("rst_eadr", par_err_adr, 0);
    chk("rst_ecnt", err_cnt, 0);
    chk("rst_pdack", pd_ack, 0);
    chk("rst_rdy", bus.rdy, 0);

    reset = 1'b0;
    repeat (100) @(negedge CLK);
    chk("init_busy", bus.rdy, 0);
    reset = 1'b1;
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    wait_rdy(n);
    chk("init_len", n, DEPTH);

    issue(0, 9'd0, '0, 0);
    issue(0, 9'd255, '0, 0);
    issue(0, 9'd511, '0, 0);

    issue(1, 9'h1F3, 8'hA5, 0);
    issue(0, 9'h1F3, '0, 0);

    issue(1, 9'h010, 8'h3C, 1);
    issue(0, 9'h010, '0, 0);
    issue(0, 9'h010, '0, 0);
    repeat (3) @(negedge CLK);
    chk("err_cnt_two", err_cnt, 2);
    chk("err_adr_010", par_err_adr, 9'h010);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) @(negedge CLK);
      else issue(1'($urandom), AW'($urandom_range(63)),
                 DW'($urandom), $urandom_range(7) == 0);
    end

    issue(1, 9'h020, 8'h5A, 1);
    repeat (300) issue(0, 9'h020, '0, 0);
    repeat (3) @(negedge CLK);
    chk("err_sat", err_cnt, CMAX);

    pd_req = 1'b1;
    issue(0, 9'h005, '0, 0);
    k = 0;
    while (!pd_ack && k < 20) begin
      @(negedge CLK);
      k++;
    end
    chk("pd_ack", pd_ack, 1);
    chk("pd_rdy", bus.rdy, 0);
    repeat (4) issue(1, 9'h005, DW'($urandom), 0);
    repeat (2) issue(0, 9'h005, '0, 0);
    chk("pd_hold", pd_ack, 1);
    pd_req = 1'b0;
    n = 0;
    k = 0;
    while (!bus.rdy && k < 50) begin
      @(negedge CLK);
      k++;
      if (!pd_ack && !bus.rdy) n++;
    end
    chk("wake_len", n, WAKE);
    issue(0, 9'h005, '0, 0);

    issue(1, 9'h030, 8'hC3, 0);
    scan_mode = 1'b1;
    @(negedge CLK);
    chk("scan_rdy", bus.rdy, 0);
    repeat (10) issue(1, 9'h030, DW'($urandom), 0);
    scan_mode = 1'b0;
    @(negedge CLK);
    issue(0, 9'h030, '0, 0);

    repeat (4) @(negedge CLK);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_sp_par_wrap.md
Name: sram_sp_par_wrap

Overview:
- Parametrised single-port SRAM wrapper; successor to the fixed 512x8 wrapper.
- Stores one even-parity bit per word and checks it on every read, with error injection for test.
- Runs a post-reset clear engine and a power-down/wake sequencer.
- Sits between peripheral/CPU memory clients and a behavioural storage array of DEPTH x (DW+1) bits.

Parameters:
- DW, 8: data width in bits (1..64).
- AW, 9: address width; DEPTH = 2**AW words.
- INIT_ON_RESET, 1: 1 = clear every word (data 0, parity 0) after reset; 0 = skip straight to IDLE.
- WAKE_CYC, 4: cycles spent in WAKE after power-down exit (>=1).
- ERRCNT_W, 8: width of the saturating parity-error counter.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous reset, active-high.
- ME  in  1  memory enable; an access is accepted when ME=1 and rdy=1.
- WE  in  1  1 = write, 0 = read (sampled with ME).
- ADR  in  AW  word address.
- D  in  DW  write data.
- inj_par  in  1  on an accepted write, store the inverted parity bit.
- pd_req  in  1  level request to enter power-down.
- scan_mode  in  1  1 forces rdy=0 and blocks all accesses; FSM state is held.
- Q  out  DW  read data.
- Q_vld  out  1  one-cycle pulse; Q is valid.
- par_err  out  1  one-cycle pulse, coincident with Q_vld, on a parity mismatch.
- par_err_adr  out  AW  address of the most recent parity error (held).
- err_cnt  out  ERRCNT_W  saturating count of parity errors.
- rdy  out  1  state==IDLE and scan_mode=0.
- pd_ack  out  1  1 while in PD.

Behaviour:
- Reset (reset=1 at a clock edge):
  - Outputs: Q=0, Q_vld=0, par_err=0, par_err_adr=0, err_cnt=0, pd_ack=0, rdy=0.
  - Next state: INIT if INIT_ON_RESET=1, else IDLE.
  - Array contents are not reset.
  - Reset asserted in any state (mid-INIT, PD, WAKE) restarts from this point.
- States: INIT, IDLE, PD, WAKE.
- INIT:
  - Internal counter writes {parity 0, data 0} to address 0..DEPTH-1, one word per cycle.
  - Moves to IDLE the cycle after address DEPTH-1 is written, so INIT lasts exactly DEPTH cycles.
  - ME is ignored throughout.
- IDLE, write (ME=1, WE=1):
  - mem[ADR] <= {^D ^ inj_par, D} at the edge.
  - No Q_vld pulse.
- IDLE, read (ME=1, WE=0):
  - Latency 1: Q = data, Q_vld=1 in the following cycle.
  - par_err = stored parity != ^data.
  - On par_err: par_err_adr <= ADR of that read; err_cnt increments, saturating at all-ones.
- Back-to-back accesses are accepted every cycle.
- A read of an address written in the previous cycle returns the new data.
- Q holds its last value when Q_vld=0.
- IDLE -> PD when pd_req=1 and no access is accepted that cycle. If ME=1 and pd_req=1 together, the access is served and PD is entered on the next eligible cycle.
- PD:
  - pd_ack=1, rdy=0; contents retained; accesses ignored.
  - pd_req=0 -> WAKE.
- WAKE:
  - Down-counter from WAKE_CYC-1.
  - At 0 -> IDLE, so exactly WAKE_CYC cycles are spent in WAKE.
  - pd_req re-asserted during WAKE has no effect until IDLE.
- A read accepted in the cycle before leaving IDLE still produces its Q_vld in the next cycle.
- scan_mode=1: no state change, no counters advance, no array writes, Q_vld/par_err=0. Registers hold their values.
- Parity is computed over DW bits only.

Test Plan:
- Reset, DW=8/AW=9/INIT_ON_RESET=1: rdy rises exactly 512 cycles after reset drops. Reads of addresses 0, 255 and 511 return Q=0x00 with par_err=0.
- Write 0xA5 to 0x1F3, then read 0x1F3 in the next cycle: Q=0xA5 with Q_vld exactly one cycle after the read; par_err=0.
- Write 0x3C to 0x010 with inj_par=1, then read 0x010 twice: two par_err pulses, par_err_adr=0x010, err_cnt=2. With ERRCNT_W=2, 5 erroneous reads leave err_cnt=3.
- In IDLE, hold ME=1/WE=0 at 0x005 with pd_req=1: the read is served (Q_vld next cycle) and PD is entered afterwards (pd_ack=1). Access attempts during PD are ignored and data is retained. Drop pd_req: rdy returns after exactly WAKE_CYC=4 cycles.
- Assert reset at INIT address 100, release, and verify the full 512-cycle INIT reruns. Assert scan_mode=1 for 10 cycles in IDLE with ME=1/WE=1: no write occurs, and the prior contents read back unchanged after release.
